// File: rtl/gcc_poll_tx.sv
// GameCube controller poll transmitter: sends the 24-bit poll command and a stop bit, then holds the line released for the response window.
// Optional GCC_AUTO_POLL_EN adds a free-running period counter that issues polls on its own.
`timescale 1ns/1ps
module gcc_poll_tx #(
    parameter int CLKS_PER_US    = 50,
    parameter int RESP_WINDOW_US = 400,
    parameter int POLL_PERIOD_US = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rumble,
    input  logic line_in,
    output logic line_oe,
    output logic enable,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        RESP_WAIT
    } state_t;

    localparam logic [TIMER_W-1:0] LAST_1US  = TIMER_W'(CLKS_PER_US - 1);
    localparam logic [TIMER_W-1:0] LAST_3US  = TIMER_W'(3 * CLKS_PER_US - 1);
    localparam logic [TIMER_W-1:0] LAST_RESP = TIMER_W'(RESP_WINDOW_US * CLKS_PER_US - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [4:0]         bit_idx;
    logic               rumble_q;
    logic [23:0]        cmd;
    logic               cur_bit;
    logic               request;
    logic               accept;
    logic               done_next;

    assign cmd     = {8'h40, 8'h03, 7'b0, rumble_q};
    assign cur_bit = cmd[bit_idx];

`ifdef GCC_AUTO_POLL_EN
    localparam logic [TIMER_W-1:0] LAST_POLL = TIMER_W'(POLL_PERIOD_US * CLKS_PER_US - 1);

    logic [TIMER_W-1:0] poll_cnt;
    logic               poll_trig;
    logic               poll_pending;

    assign poll_trig = (poll_cnt == LAST_POLL);
    assign request   = start | poll_trig | poll_pending;

    // A trigger that lands while busy (or while the line is held low) waits here until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            if (accept || poll_trig)
                poll_cnt <= '0;
            else
                poll_cnt <= poll_cnt + 1'b1;

            if (accept)
                poll_pending <= 1'b0;
            else if (poll_trig)
                poll_pending <= 1'b1;
        end
    end
`else
    assign request = start;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (request && line_in) begin
                    accept     = 1'b1;
                    state_next = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (timer == (cur_bit ? LAST_1US : LAST_3US))
                    state_next = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (timer == (cur_bit ? LAST_3US : LAST_1US))
                    state_next = (bit_idx == 5'd0) ? STOP_LOW : BIT_LOW;
            end
            STOP_LOW: begin
                if (timer == LAST_1US)
                    state_next = RESP_WAIT;
            end
            RESP_WAIT: begin
                if (timer == LAST_RESP) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= 5'd0;
            rumble_q <= 1'b0;
            line_oe  <= 1'b0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state || state == IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (accept) begin
                rumble_q <= rumble;
                bit_idx  <= 5'd23;
            end else if (state == BIT_HIGH && state_next == BIT_LOW) begin
                bit_idx <= bit_idx - 1'b1;
            end

            line_oe <= (state_next == BIT_LOW) || (state_next == STOP_LOW);
            enable  <= (state_next == BIT_LOW) || (state_next == BIT_HIGH) ||
                       (state_next == STOP_LOW);
            busy    <= (state_next != IDLE);
            done    <= done_next;
        end
    end

endmodule

// File: tb/tb_gcc_poll_tx.sv
// Self-checking bench for gcc_poll_tx: decodes line_oe pulses back into command words and scores them against expected frames.
`timescale 1ns/1ps
module tb_gcc_poll_tx;

    localparam int CLKS     = 50;
    localparam int RESP_US  = 100;
    localparam int POLL_US  = 300;
    localparam int TW       = 16;
    localparam int EN_FALL  = 24 * 4 * CLKS + CLKS;
    localparam int FRAME    = EN_FALL + RESP_US * CLKS;
    localparam int POLL_CYC = POLL_US * CLKS;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic rumble;
    logic line_in;
    logic line_oe;
    logic enable;
    logic busy;
    logic done;

    gcc_poll_tx #(
        .CLKS_PER_US   (CLKS),
        .RESP_WINDOW_US(RESP_US),
        .POLL_PERIOD_US(POLL_US),
        .TIMER_W       (TW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rumble (rumble),
        .line_in(line_in),
        .line_oe(line_oe),
        .enable (enable),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rumble;
        logic        mid_start;
        logic [23:0] exp_word;
    } vec_t;

    vec_t        vecs[3];
    logic [23:0] exp_q[$];
    int          acc_times[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;

    logic        prev_oe   = 1'b0;
    logic        prev_en   = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;
    int          low_run   = 0;
    int          nbits     = 0;
    int          bad_len   = 0;
    int          stop_len  = 0;
    int          t_acc     = 0;
    int          t_en_fall = 0;
    logic [23:0] word      = '0;
    logic [23:0] exp_word_cur;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic rum);
        @(negedge clk);
        start   = 1'b1;
        rumble  = rum;
        line_in = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rumble = ~rum;
        checkOutput("accept_latency", busy, 1);
    endtask

    task automatic waitDones(input int n, input int budget, input string name);
        int target;
        int k;
        target = done_cnt + n;
        k      = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, int'(done_cnt >= target), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: low runs of 1us/3us are '1'/'0'; the run after the 24th bit is the stop bit.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            t_acc     = cyc;
            acc_times.push_back(cyc);
            nbits     = 0;
            bad_len   = 0;
            stop_len  = 0;
            word      = '0;
            low_run   = 0;
            t_en_fall = -1;
        end
        if (line_oe) begin
            low_run++;
        end else if (prev_oe) begin
            if (nbits < 24) begin
                if (low_run == CLKS)
                    word = {word[22:0], 1'b1};
                else if (low_run == 3 * CLKS)
                    word = {word[22:0], 1'b0};
                else
                    bad_len++;
                nbits++;
            end else begin
                stop_len = low_run;
            end
            low_run = 0;
        end
        if (prev_en && !enable)
            t_en_fall = cyc;
        if (prev_done)
            checkOutput("done_width", done, 0);
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_word_cur = exp_q.pop_front();
                checkOutput("cmd_word", word, exp_word_cur);
                checkOutput("bit_cells", nbits * 1000 + bad_len, 24000);
                checkOutput("stop_low", stop_len, CLKS);
                checkOutput("done_latency", cyc - t_acc, FRAME);
                checkOutput("enable_fall", t_en_fall - t_acc, EN_FALL);
            end
        end
        prev_oe   = line_oe;
        prev_en   = enable;
        prev_busy = busy;
        prev_done = done;
    end

    initial begin
        int viol;
        int saved_done;

        reset   = 1'b1;
        start   = 1'b0;
        rumble  = 1'b0;
        line_in = 1'b1;
        vecs[0] = '{1'b0, 1'b0, 24'h400300};
        vecs[1] = '{1'b1, 1'b0, 24'h400301};
        vecs[2] = '{1'b0, 1'b1, 24'h400300};

        repeat (3) @(negedge clk);
        checkOutput("reset_line_oe", line_oe, 0);
        checkOutput("reset_enable", enable, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;

`ifdef GCC_AUTO_POLL_EN
        repeat (3) exp_q.push_back(24'h400300);
        waitDones(3, 3 * POLL_CYC + FRAME + 100, "auto_dones");
        checkOutput("auto_frames", acc_times.size(), 3);
        if (acc_times.size() >= 3) begin
            checkOutput("auto_period_1", acc_times[1] - acc_times[0], POLL_CYC);
            checkOutput("auto_period_2", acc_times[2] - acc_times[1], POLL_CYC);
        end
`else
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].rumble);
            exp_q.push_back(vecs[i].exp_word);
            if (vecs[i].mid_start) begin
                repeat (1000) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            waitDones(1, FRAME + 200, "frame_done");
            repeat (200) @(negedge clk);
            checkOutput("idle_after_done", busy, 0);
            checkOutput("queue_drained", exp_q.size(), 0);
        end

        // Line held low by someone else: the request must wait, then go on the first free cycle.
        line_in = 1'b0;
        start   = 1'b1;
        rumble  = 1'b1;
        viol    = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || enable || line_oe || done)
                viol++;
        end
        checkOutput("line_low_hold_off", viol, 0);
        exp_q.push_back(24'h400301);
        line_in = 1'b1;
        @(negedge clk);
        checkOutput("line_release_start", busy, 1);
        start  = 1'b0;
        rumble = 1'b0;
        repeat (EN_FALL + 10) @(negedge clk);
        line_in = 1'b0;
        repeat (500) @(negedge clk);
        line_in = 1'b1;
        waitDones(1, FRAME, "resp_activity_done");

        // Reset in the middle of bit 10's low phase.
        saved_done = done_cnt;
        applyStimulus(1'b0);
        repeat (13 * 4 * CLKS + 20) @(negedge clk);
        checkOutput("bit10_low", line_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_line_oe", line_oe, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_enable", enable, 0);
        checkOutput("abort_done", done, 0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("no_done_after_abort", done_cnt, saved_done);

        applyStimulus(1'b1);
        exp_q.push_back(24'h400301);
        waitDones(1, FRAME + 200, "post_abort_done");
        repeat (20) @(negedge clk);
        checkOutput("final_queue_drained", exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
